branch_predictor_param: RTL and testbench

Parametrised branch direction predictor for the lab4 processor fetch stage. It supports three modes: PC-indexed bimodal, two-level local history, and gshare. Each mode uses a table of saturating counters, the PHT. After reset, an init state machine sweeps the tables to a known state before the block reports ready. Two 32-bit statistics counters, `upd_count` and `mispred_count`, track updates and mispredictions.

---
 rtl/branch_predictor_param.sv | 140 ++++++++++++++
 tb/tb_branch_predictor_param.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_param.sv
// Branch direction predictor: bimodal, local two-level or gshare indexing into a
// saturating-counter PHT, with a post-reset table sweep and saturating statistics.
module branch_predictor_param #(
    parameter int unsigned PHT_ENTRIES = 2048,
    parameter int unsigned BHT_ENTRIES = 4,
    parameter int unsigned CTR_BITS    = 2,
    parameter int unsigned MODE        = 0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ready,
    input  logic [31:0] pred_pc,
    output logic        pred_taken,
    input  logic        update_en,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic        update_pred,
    output logic [31:0] upd_count,
    output logic [31:0] mispred_count
);

    localparam int unsigned PHT_AW = $clog2(PHT_ENTRIES);
    localparam int unsigned BHT_AW = $clog2(BHT_ENTRIES);
    localparam logic [CTR_BITS-1:0] CTR_WNT  = CTR_BITS'((32'd1 << (CTR_BITS - 1)) - 32'd1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [PHT_AW-1:0]   IDX_LAST = PHT_AW'(PHT_ENTRIES - 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t state_q, state_d;
    logic [PHT_AW-1:0]   init_idx_q, init_idx_d;
    logic [CTR_BITS-1:0] pht [PHT_ENTRIES];
    logic [PHT_AW-1:0]   bht [BHT_ENTRIES];
    logic [PHT_AW-1:0]   ghr;

    logic [BHT_AW-1:0]   pred_bht_idx, upd_bht_idx;
    logic [PHT_AW-1:0]   pred_idx, upd_idx;
    logic [PHT_AW-1:0]   bht_old, bht_new;
    logic [CTR_BITS-1:0] ctr_old, ctr_new;
    logic                upd_accept;
    logic                unused_pc_bits;

    assign unused_pc_bits = ^{pred_pc, update_pc};

    // Index selection for both the predict and the update port
    always_comb begin
        pred_bht_idx = pred_pc[BHT_AW+1:2];
        upd_bht_idx  = update_pc[BHT_AW+1:2];
        bht_old      = bht[upd_bht_idx];
        bht_new      = {bht_old[PHT_AW-2:0], update_taken};
        if (MODE == 1) begin
            pred_idx = bht[pred_bht_idx];
            upd_idx  = bht_old;
        end else if (MODE == 2) begin
            pred_idx = pred_pc[PHT_AW+1:2] ^ ghr;
            upd_idx  = update_pc[PHT_AW+1:2] ^ ghr;
        end else begin
            pred_idx = pred_pc[PHT_AW+1:2];
            upd_idx  = update_pc[PHT_AW+1:2];
        end
    end

    // Saturating counter step
    always_comb begin
        ctr_old = pht[upd_idx];
        ctr_new = ctr_old;
        if (update_taken) begin
            if (ctr_old != CTR_MAX) ctr_new = ctr_old + CTR_BITS'(1);
        end else begin
            if (ctr_old != '0) ctr_new = ctr_old - CTR_BITS'(1);
        end
    end

    // Next-state and prediction
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        pred_taken = 1'b0;
        upd_accept = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_idx_d = init_idx_q + PHT_AW'(1);
                if (init_idx_q == IDX_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                pred_taken = pht[pred_idx][CTR_BITS-1];
                upd_accept = update_en;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_INIT;
            init_idx_q <= '0;
            ready      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            ready      <= (state_d == ST_RUN);
        end
    end

    // Tables are not reset; the sweep establishes their contents
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == ST_INIT) begin
                pht[init_idx_q] <= CTR_WNT;
                if (32'(init_idx_q) < BHT_ENTRIES) bht[init_idx_q[BHT_AW-1:0]] <= '0;
            end else if (upd_accept) begin
                pht[upd_idx] <= ctr_new;
                if (MODE == 1) bht[upd_bht_idx] <= bht_new;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ghr <= '0;
        end else if (upd_accept && (MODE == 2)) begin
            ghr <= {ghr[PHT_AW-2:0], update_taken};
        end
    end

    // Statistics hold at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            upd_count     <= '0;
            mispred_count <= '0;
        end else if (upd_accept) begin
            if (upd_count != '1) upd_count <= upd_count + 32'd1;
            if ((update_pred != update_taken) && (mispred_count != '1))
                mispred_count <= mispred_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor_param.sv
// Directed bench: one instance per mode sharing all inputs; each test checks its own instance.
module tb_branch_predictor_param;

    logic        clk;
    logic        reset;
    logic [31:0] pred_pc;
    logic        update_en;
    logic [31:0] update_pc;
    logic        update_taken;
    logic        update_pred;

    logic        ready_bim, ready_loc, ready_gsh;
    logic        pred_bim, pred_loc, pred_gsh;
    logic [31:0] upd_bim, upd_loc, upd_gsh;
    logic [31:0] mis_bim, mis_loc, mis_gsh;

    int n_checks;
    int n_fail;

    branch_predictor_param #(.PHT_ENTRIES(16), .BHT_ENTRIES(4), .CTR_BITS(2), .MODE(0)) u_bim (
        .clk(clk), .reset(reset), .ready(ready_bim), .pred_pc(pred_pc), .pred_taken(pred_bim),
        .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
        .update_pred(update_pred), .upd_count(upd_bim), .mispred_count(mis_bim));

    branch_predictor_param #(.PHT_ENTRIES(16), .BHT_ENTRIES(4), .CTR_BITS(2), .MODE(1)) u_loc (
        .clk(clk), .reset(reset), .ready(ready_loc), .pred_pc(pred_pc), .pred_taken(pred_loc),
        .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
        .update_pred(update_pred), .upd_count(upd_loc), .mispred_count(mis_loc));

    branch_predictor_param #(.PHT_ENTRIES(16), .BHT_ENTRIES(4), .CTR_BITS(2), .MODE(2)) u_gsh (
        .clk(clk), .reset(reset), .ready(ready_gsh), .pred_pc(pred_pc), .pred_taken(pred_gsh),
        .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
        .update_pred(update_pred), .upd_count(upd_gsh), .mispred_count(mis_gsh));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pc(input logic [31:0] pc);
        pred_pc = pc;
        #1;
    endtask

    task automatic do_update(input logic [31:0] pc, input logic taken, input logic pred);
        update_en    = 1'b1;
        update_pc    = pc;
        update_taken = taken;
        update_pred  = pred;
        tick();
        update_en    = 1'b0;
    endtask

    task automatic reset_and_sweep();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        repeat (16) tick();
    endtask

    task automatic test_reset_init();
        reset = 1'b1;
        set_pc(32'h100);
        tick();
        n_checks++;
        if (ready_bim !== 1'b0 || pred_bim !== 1'b0 || upd_bim !== 32'd0 || mis_bim !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b pred=%b upd=%0d mis=%0d, required 0/0/0/0",
                     ready_bim, pred_bim, upd_bim, mis_bim);
        end
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            if (k == 5) begin
                update_en    = 1'b1;
                update_pc    = 32'h100;
                update_taken = 1'b1;
                update_pred  = 1'b0;
            end
            tick();
            update_en = 1'b0;
            n_checks++;
            if (ready_bim !== (k == 16)) begin
                n_fail++;
                $display("FAIL init_ready edge %0d: got %b, required %b", k, ready_bim, (k == 16));
            end
            if (k < 16) begin
                n_checks++;
                if (pred_bim !== 1'b0) begin
                    n_fail++;
                    $display("FAIL init_pred edge %0d: got %b, required 0", k, pred_bim);
                end
            end
        end
        n_checks++;
        if (ready_loc !== 1'b1 || ready_gsh !== 1'b1) begin
            n_fail++;
            $display("FAIL init_ready_modes: loc=%b gsh=%b, required 1/1", ready_loc, ready_gsh);
        end
        n_checks++;
        if (upd_bim !== 32'd0 || mis_bim !== 32'd0) begin
            n_fail++;
            $display("FAIL init_drop: upd=%0d mis=%0d, required 0/0", upd_bim, mis_bim);
        end
        n_checks++;
        if (pred_bim !== 1'b0) begin
            n_fail++;
            $display("FAIL init_pred_100: got %b, required 0", pred_bim);
        end
    endtask

    task automatic test_bimodal();
        reset_and_sweep();
        set_pc(32'h100);
        repeat (2) do_update(32'h100, 1'b1, 1'b1);   // 01 -> 11
        n_checks++;
        if (pred_bim !== 1'b1) begin
            n_fail++;
            $display("FAIL bim_two_taken: got %b, required 1", pred_bim);
        end
        repeat (3) do_update(32'h100, 1'b1, 1'b1);   // stays 11
        n_checks++;
        if (pred_bim !== 1'b1) begin
            n_fail++;
            $display("FAIL bim_sat_high: got %b, required 1", pred_bim);
        end
        set_pc(32'h140);
        n_checks++;
        if (pred_bim !== 1'b1) begin
            n_fail++;
            $display("FAIL bim_alias_140: got %b, required 1", pred_bim);
        end
        set_pc(32'h104);
        n_checks++;
        if (pred_bim !== 1'b0) begin
            n_fail++;
            $display("FAIL bim_other_index: got %b, required 0", pred_bim);
        end
        set_pc(32'h100);
        do_update(32'h100, 1'b0, 1'b1);               // 10
        n_checks++;
        if (pred_bim !== 1'b1) begin
            n_fail++;
            $display("FAIL bim_one_nt: got %b, required 1", pred_bim);
        end
        repeat (2) do_update(32'h100, 1'b0, 1'b1);   // 00
        n_checks++;
        if (pred_bim !== 1'b0) begin
            n_fail++;
            $display("FAIL bim_two_nt: got %b, required 0", pred_bim);
        end
        do_update(32'h100, 1'b0, 1'b1);               // stays 00
        do_update(32'h100, 1'b1, 1'b1);               // 01
        n_checks++;
        if (pred_bim !== 1'b0) begin
            n_fail++;
            $display("FAIL bim_sat_low: got %b, required 0", pred_bim);
        end
        update_en    = 1'b1;
        update_pc    = 32'h100;
        update_taken = 1'b1;
        update_pred  = 1'b1;
        #1;
        n_checks++;
        if (pred_bim !== 1'b0) begin
            n_fail++;
            $display("FAIL bim_no_bypass: got %b, required 0", pred_bim);
        end
        tick();
        update_en = 1'b0;
        n_checks++;
        if (pred_bim !== 1'b1) begin
            n_fail++;
            $display("FAIL bim_after_update: got %b, required 1", pred_bim);
        end
        n_checks++;
        if (upd_bim !== 32'd11 || mis_bim !== 32'd4) begin
            n_fail++;
            $display("FAIL bim_stats: upd=%0d mis=%0d, required 11/4", upd_bim, mis_bim);
        end
    endtask

    task automatic test_local();
        logic taken;
        reset_and_sweep();
        set_pc(32'h104);
        for (int i = 0; i < 40; i++) begin
            taken = (i % 2 == 0);
            if (i >= 32) begin
                n_checks++;
                if (pred_loc !== taken) begin
                    n_fail++;
                    $display("FAIL loc_pred update %0d: got %b, required %b", i, pred_loc, taken);
                end
            end
            do_update(32'h104, taken, pred_loc);
        end
        n_checks++;
        if (upd_loc !== 32'd40 || mis_loc !== 32'd3) begin
            n_fail++;
            $display("FAIL loc_stats: upd=%0d mis=%0d, required 40/3", upd_loc, mis_loc);
        end
    endtask

    task automatic test_gshare();
        reset_and_sweep();
        do_update(32'h0, 1'b1, 1'b0);   // pht[0]=10
        do_update(32'h0, 1'b1, 1'b0);   // pht[1]=10
        do_update(32'h0, 1'b0, 1'b0);   // pht[3]=00
        n_checks++;
        if (u_gsh.ghr !== 4'b0110) begin
            n_fail++;
            $display("FAIL gsh_ghr_ttn: got %b, required 0110", u_gsh.ghr);
        end
        set_pc(32'h0);
        n_checks++;
        if (pred_gsh !== 1'b0) begin
            n_fail++;
            $display("FAIL gsh_pred_0: got %b, required 0", pred_gsh);
        end
        set_pc(32'h18);
        n_checks++;
        if (pred_gsh !== 1'b1) begin
            n_fail++;
            $display("FAIL gsh_pred_18: got %b, required 1", pred_gsh);
        end
        do_update(32'h0, 1'b1, 1'b0);   // pht[6]=10, ghr 1101
        do_update(32'h0, 1'b1, 1'b0);   // pht[13]=10, ghr 1011
        n_checks++;
        if (u_gsh.ghr !== 4'b1011) begin
            n_fail++;
            $display("FAIL gsh_ghr_final: got %b, required 1011", u_gsh.ghr);
        end
        set_pc(32'h0);
        n_checks++;
        if (pred_gsh !== 1'b0) begin
            n_fail++;
            $display("FAIL gsh_pred_0_final: got %b, required 0", pred_gsh);
        end
        set_pc(32'h34);
        n_checks++;
        if (pred_gsh !== 1'b1) begin
            n_fail++;
            $display("FAIL gsh_pred_34: got %b, required 1", pred_gsh);
        end
        set_pc(32'h18);
        n_checks++;
        if (pred_gsh !== 1'b1) begin
            n_fail++;
            $display("FAIL gsh_pred_18_final: got %b, required 1", pred_gsh);
        end
        n_checks++;
        if (upd_gsh !== 32'd5 || mis_gsh !== 32'd4) begin
            n_fail++;
            $display("FAIL gsh_stats: upd=%0d mis=%0d, required 5/4", upd_gsh, mis_gsh);
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        repeat (7) tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if (ready_bim !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_sweep_reset_ready: got %b, required 0", ready_bim);
        end
        reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            n_checks++;
            if (ready_bim !== (k == 16)) begin
                n_fail++;
                $display("FAIL resweep_ready edge %0d: got %b, required %b", k, ready_bim, (k == 16));
            end
        end
        set_pc(32'h100);
        repeat (2) do_update(32'h100, 1'b1, 1'b0);
        n_checks++;
        if (pred_bim !== 1'b1 || upd_bim !== 32'd2 || mis_bim !== 32'd2) begin
            n_fail++;
            $display("FAIL mid_run_train: pred=%b upd=%0d mis=%0d, required 1/2/2",
                     pred_bim, upd_bim, mis_bim);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (upd_bim !== 32'd0 || mis_bim !== 32'd0 || ready_bim !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_run_reset: upd=%0d mis=%0d ready=%b, required 0/0/0",
                     upd_bim, mis_bim, ready_bim);
        end
        reset = 1'b0;
        repeat (16) tick();
        n_checks++;
        if (ready_bim !== 1'b1 || pred_bim !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_run_resweep: ready=%b pred=%b, required 1/0", ready_bim, pred_bim);
        end
        do_update(32'h100, 1'b1, 1'b1);   // WNT 01 -> 10
        n_checks++;
        if (pred_bim !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_run_wnt: got %b, required 1", pred_bim);
        end
    endtask

    task automatic test_saturation();
        reset_and_sweep();
        force u_bim.upd_count     = 32'hFFFF_FFFF;
        force u_bim.mispred_count = 32'hFFFF_FFFF;
        update_en    = 1'b1;
        update_pc    = 32'h100;
        update_taken = 1'b1;
        update_pred  = 1'b0;
        tick();
        release u_bim.upd_count;
        release u_bim.mispred_count;
        tick();
        n_checks++;
        if (mis_bim !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL sat_mispred_1: got %h, required ffffffff", mis_bim);
        end
        tick();
        update_en = 1'b0;
        n_checks++;
        if (mis_bim !== 32'hFFFF_FFFF || upd_bim !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL sat_counters: mis=%h upd=%h, required ffffffff/ffffffff", mis_bim, upd_bim);
        end
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        reset        = 1'b1;
        pred_pc      = 32'h0;
        update_en    = 1'b0;
        update_pc    = 32'h0;
        update_taken = 1'b0;
        update_pred  = 1'b0;
        test_reset_init();
        test_bimodal();
        test_local();
        test_gshare();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
